nios_sampler_pio_irq: RTL and testbench

Parametrised Avalon-MM general-purpose I/O slave for the sampler Nios II subsystem: a WIDTH-bit output register with atomic set/clear access, a synchronised WIDTH-bit input port with per-bit edge capture, and a maskable level interrupt to the CPU. It supersedes the fixed 8-bit output-only PIO wherever firmware needs to read board status lines or be interrupted on their transitions.

---
 rtl/nios_sampler_pio_irq.sv | 102 ++++++++++
 tb/tb_nios_sampler_pio_irq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_sampler_pio_irq.sv
// Avalon-MM GPIO slave: set/clear output register, synchronised inputs with per-bit edge
// capture and a maskable level irq. Zero-latency reads; writes land on the write-cycle edge.
module nios_sampler_pio_irq #(
  parameter int               WIDTH       = 8,
  parameter int               EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_OUTPUT = 3'd1;
  localparam logic [2:0] A_MASK   = 3'd2;
  localparam logic [2:0] A_EDGE   = 3'd3;
  localparam logic [2:0] A_OUTSET = 3'd4;
  localparam logic [2:0] A_OUTCLR = 3'd5;

  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [1:0]       warm_q, warm_d;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] evt;
  logic             wr;
  logic             wdat_unused;

  assign wr          = chipselect & ~write_n;
  assign wdat        = writedata[WIDTH-1:0];
  assign wdat_unused = ^writedata;

  // Events are suppressed until the synchroniser pipeline holds post-reset samples.
  always_comb begin
    evt = sync2_q & ~prev_q;
    if (EDGE_TYPE == 1) evt = ~sync2_q & prev_q;
    else if (EDGE_TYPE == 2) evt = sync2_q ^ prev_q;
    if (warm_q != 2'd3) evt = '0;
  end

  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    cap_d  = cap_q;
    warm_d = (warm_q == 2'd3) ? 2'd3 : warm_q + 2'd1;
    if (wr) begin
      case (address)
        A_DATA, A_OUTPUT: out_d = wdat;
        A_MASK:           mask_d = wdat;
        A_EDGE:           cap_d = cap_q & ~wdat;
        A_OUTSET:         out_d = out_q | wdat;
        A_OUTCLR:         out_d = out_q & ~wdat;
        default:          ;
      endcase
    end
    // A new event on the same bit as a clear keeps the bit set.
    cap_d = cap_d | evt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      out_q   <= RESET_VALUE;
      mask_q  <= '0;
      cap_q   <= '0;
      warm_q  <= 2'd0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      out_q   <= out_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      warm_q  <= warm_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:   readdata[WIDTH-1:0] = sync2_q;
      A_OUTPUT: readdata[WIDTH-1:0] = out_q;
      A_MASK:   readdata[WIDTH-1:0] = mask_q;
      A_EDGE:   readdata[WIDTH-1:0] = cap_q;
      default:  readdata = '0;
    endcase
  end

  assign out_port = out_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios_sampler_pio_irq.sv
// Bench for nios_sampler_pio_irq: four instances (8-bit rising, 8-bit any-edge,
// 32-bit falling, 1-bit rising) sharing clock, reset and bus lines.
module tb_nios_sampler_pio_irq;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic [3:0]  cs;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] rd_a, rd_b, rd_c, rd_d;
  logic [7:0]  in_a, out_a, in_b, out_b;
  logic [31:0] in_c, out_c;
  logic [0:0]  in_d, out_d;
  logic        irq_a, irq_b, irq_c, irq_d;

  int          errors;
  int          checks;
  logic [31:0] exp_q[$];
  logic [31:0] got;
  logic [31:0] exp;

  nios_sampler_pio_irq #(.WIDTH(8), .EDGE_TYPE(0), .RESET_VALUE(8'hA5)) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[0]), .write_n(write_n),
    .writedata(writedata), .readdata(rd_a), .in_port(in_a), .out_port(out_a), .irq(irq_a));

  nios_sampler_pio_irq #(.WIDTH(8), .EDGE_TYPE(2), .RESET_VALUE(8'h00)) dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[1]), .write_n(write_n),
    .writedata(writedata), .readdata(rd_b), .in_port(in_b), .out_port(out_b), .irq(irq_b));

  nios_sampler_pio_irq #(.WIDTH(32), .EDGE_TYPE(1), .RESET_VALUE(32'h8000_0001)) dut_c (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[2]), .write_n(write_n),
    .writedata(writedata), .readdata(rd_c), .in_port(in_c), .out_port(out_c), .irq(irq_c));

  nios_sampler_pio_irq #(.WIDTH(1), .EDGE_TYPE(0), .RESET_VALUE(1'b0)) dut_d (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[3]), .write_n(write_n),
    .writedata(writedata), .readdata(rd_d), .in_port(in_d), .out_port(out_d), .irq(irq_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tasks start and end 1 time unit after a rising edge (reads leave it at +2).
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input int inst, input logic [2:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs        = '0;
    cs[inst]  = 1'b1;
    @(posedge clk);
    #1;
    write_n = 1'b1;
    cs      = '0;
  endtask

  task automatic bus_rd(input int inst, input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    case (inst)
      0:       d = rd_a;
      1:       d = rd_b;
      2:       d = rd_c;
      default: d = rd_d;
    endcase
  endtask

  task automatic test_reset;
    reset = 1'b1; in_a = 8'hFF; in_b = 8'h00; in_c = '1; in_d = 1'b1;
    cs = '0; write_n = 1'b1; address = '0; writedata = '0;
    tick(3);
    exp_q.push_back(32'hA5);
    exp = exp_q.pop_front(); got = {24'h0, out_a}; checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_out_a got %h want %h", got, exp); end
    exp_q.push_back(32'h8000_0001);
    exp = exp_q.pop_front(); got = out_c; checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_out_c got %h want %h", got, exp); end
    checks++;
    if ({irq_a, irq_b, irq_c, irq_d, out_b, out_d} !== 13'h0) begin
      errors++; $display("FAIL reset_irq_out got %b want 0", {irq_a, irq_b, irq_c, irq_d, out_b, out_d});
    end
    reset = 1'b0;
    tick(10);
    exp_q.push_back(32'h0);
    bus_rd(0, 3'd3, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL warmup_cap_a got %h want %h", got, exp); end
    exp_q.push_back(32'h0);
    bus_rd(3, 3'd3, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL warmup_cap_d got %h want %h", got, exp); end
    exp_q.push_back(32'h0000_00FF);
    bus_rd(0, 3'd0, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL data_a got %h want %h", got, exp); end
    exp_q.push_back(32'h0);
    bus_rd(0, 3'd2, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL mask_a_reset got %h want %h", got, exp); end
  endtask

  task automatic test_outset_outclear;
    logic [2:0]  addrs[4] = '{3'd1, 3'd4, 3'd5, 3'd0};
    logic [31:0] datas[4] = '{32'h0F, 32'hF0, 32'h81, 32'hFFFF_FF3C};
    logic [31:0] outs[4]  = '{32'h0F, 32'hFF, 32'h7E, 32'h3C};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(outs[i]);
      bus_wr(0, addrs[i], datas[i]);
      exp = exp_q.pop_front(); got = {24'h0, out_a}; checks++;
      if (got !== exp) begin errors++; $display("FAIL out_a_step%0d got %h want %h", i, got, exp); end
      if (i == 2) begin
        bus_rd(0, 3'd4, got); checks++;
        if (got !== 32'h0) begin errors++; $display("FAIL outset_read got %h want 0", got); end
        bus_rd(0, 3'd5, got); checks++;
        if (got !== 32'h0) begin errors++; $display("FAIL outclr_read got %h want 0", got); end
      end
    end
    exp_q.push_back(32'h0000_003C);
    bus_rd(0, 3'd1, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL output_read got %h want %h", got, exp); end
  endtask

  task automatic test_rising;
    in_a = 8'h00;
    tick(5);
    bus_rd(0, 3'd3, got); checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL falling_ignored got %h want 0", got); end
    tick(1);
    bus_wr(0, 3'd2, 32'h04);
    in_a[2] = 1'b1;
    exp_q.push_back(32'h04);
    tick(2);
    bus_rd(0, 3'd3, got); checks++;
    if (got !== 32'h0 || irq_a !== 1'b0) begin
      errors++; $display("FAIL cap_early got %h irq %b want 0", got, irq_a);
    end
    tick(1);
    bus_rd(0, 3'd3, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp || irq_a !== 1'b1) begin
      errors++; $display("FAIL cap_k2 got %h irq %b want %h irq 1", got, irq_a, exp);
    end
    tick(1);
    bus_wr(0, 3'd3, 32'h04);
    checks++;
    if (irq_a !== 1'b0) begin errors++; $display("FAIL w1c_irq got %b want 0", irq_a); end
    in_a[5] = 1'b1;
    exp_q.push_back(32'h20);
    tick(3);
    bus_rd(0, 3'd3, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp || irq_a !== 1'b0) begin
      errors++; $display("FAIL masked_cap got %h irq %b want %h irq 0", got, irq_a, exp);
    end
    tick(1);
    bus_wr(0, 3'd3, 32'h20);
  endtask

  task automatic test_w1c_collision;
    in_a[2] = 1'b0;
    tick(4);
    in_a[2] = 1'b1;
    exp_q.push_back(32'h04);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus_wr(0, 3'd3, 32'h04);
    bus_rd(0, 3'd3, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp || irq_a !== 1'b1) begin
      errors++; $display("FAIL collision got %h irq %b want %h irq 1", got, irq_a, exp);
    end
    tick(1);
    bus_wr(0, 3'd3, 32'h04);
    bus_rd(0, 3'd3, got); checks++;
    if (got !== 32'h0 || irq_a !== 1'b0) begin
      errors++; $display("FAIL plain_w1c got %h irq %b want 0", got, irq_a);
    end
  endtask

  task automatic test_any_edge;
    in_b = 8'h81;
    exp_q.push_back(32'h81);
    tick(3);
    bus_rd(1, 3'd3, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp || irq_b !== 1'b0) begin
      errors++; $display("FAIL any_rise got %h irq %b want %h irq 0", got, irq_b, exp);
    end
    tick(1);
    bus_wr(1, 3'd3, 32'hFF);
    in_b = 8'h00;
    exp_q.push_back(32'h81);
    tick(3);
    bus_rd(1, 3'd3, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp || irq_b !== 1'b0) begin
      errors++; $display("FAIL any_fall got %h irq %b want %h irq 0", got, irq_b, exp);
    end
    tick(1);
    bus_wr(1, 3'd2, 32'h80);
    checks++;
    if (irq_b !== 1'b1) begin errors++; $display("FAIL mask_irq got %b want 1", irq_b); end
  endtask

  task automatic test_wide;
    bus_rd(2, 3'd1, got); checks++;
    if (got !== 32'h8000_0001) begin errors++; $display("FAIL wide_rv got %h want 80000001", got); end
    tick(1);
    exp_q.push_back(32'hFFFF_0001);
    bus_wr(2, 3'd4, 32'hFFFF_0000);
    exp = exp_q.pop_front(); checks++;
    if (out_c !== exp) begin errors++; $display("FAIL wide_set got %h want %h", out_c, exp); end
    exp_q.push_back(32'hFFFF_0000);
    bus_wr(2, 3'd5, 32'h0000_0001);
    exp = exp_q.pop_front(); checks++;
    if (out_c !== exp) begin errors++; $display("FAIL wide_clr got %h want %h", out_c, exp); end
    in_c[31] = 1'b0;
    exp_q.push_back(32'h8000_0000);
    tick(3);
    in_c[31] = 1'b1;
    tick(3);
    bus_rd(2, 3'd3, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL wide_fall got %h want %h", got, exp); end
    tick(1);
    bus_wr(2, 3'd2, 32'hFFFF_FFFF);
    bus_wr(2, 3'd7, 32'hFFFF_FFFF);
    checks++;
    if (irq_c !== 1'b1 || out_c !== 32'hFFFF_0000) begin
      errors++; $display("FAIL wide_irq_a7 irq %b out %h want 1 ffff0000", irq_c, out_c);
    end
    bus_rd(2, 3'd7, got); checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL addr7 got %h want 0", got); end
    bus_rd(2, 3'd2, got); checks++;
    if (got !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wide_mask got %h want ffffffff", got); end
  endtask

  task automatic test_narrow_and_reset;
    tick(1);
    bus_wr(3, 3'd1, 32'hFFFF_FFFE);
    checks++;
    if (out_d !== 1'b0) begin errors++; $display("FAIL narrow_out0 got %b want 0", out_d); end
    bus_wr(3, 3'd4, 32'h3);
    bus_wr(3, 3'd2, 32'hFF);
    bus_rd(3, 3'd1, got); checks++;
    if (got !== 32'h1) begin errors++; $display("FAIL narrow_out1 got %h want 1", got); end
    bus_rd(3, 3'd2, got); checks++;
    if (got !== 32'h1) begin errors++; $display("FAIL narrow_mask got %h want 1", got); end
    tick(1);
    in_d = 1'b0;
    tick(3);
    in_d = 1'b1;
    tick(3);
    checks++;
    if (irq_d !== 1'b1) begin errors++; $display("FAIL narrow_irq got %b want 1", irq_d); end
    reset = 1'b1;
    #1;
    checks++;
    if ({irq_a, irq_b, irq_c, irq_d, out_d} !== 5'b0 || out_a !== 8'hA5 || out_c !== 32'h8000_0001) begin
      errors++; $display("FAIL midreset irqs %b outs %h %h want 0 a5 80000001",
                         {irq_a, irq_b, irq_c, irq_d}, out_a, out_c);
    end
    bus_rd(3, 3'd3, got); checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL midreset_cap got %h want 0", got); end
    bus_rd(2, 3'd2, got); checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL midreset_mask got %h want 0", got); end
    tick(2);
    reset = 1'b0;
    tick(10);
    bus_rd(3, 3'd3, got); checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL rewarm_cap_d got %h want 0", got); end
    bus_rd(0, 3'd3, got); checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL rewarm_cap_a got %h want 0", got); end
    tick(1);
    in_d = 1'b0;
    tick(3);
    in_d = 1'b1;
    exp_q.push_back(32'h1);
    tick(3);
    bus_rd(3, 3'd3, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp || irq_d !== 1'b0) begin
      errors++; $display("FAIL post_reset_edge got %h irq %b want %h irq 0", got, irq_d, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset;
    test_outset_outclear;
    test_rising;
    test_w1c_collision;
    test_any_edge;
    test_wide;
    test_narrow_and_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
